mrate_adapter_rep: RTL and testbench
====================================

MRATE_ADAPTER_REP -- requirements
Module: mrate_adapter_rep

Interface
REQ-001 Parameter P_REP100, default 10: replication factor at 100 Mb/s.
REQ-002 Parameter P_REP10, default 100: replication factor at 10 Mb/s.
REQ-003 Parameter P_CW, default 7: replication counter width; SHALL satisfy 2^P_CW > P_REP10.
REQ-004 i_GClk  in  1  single clock; one clock, all logic on its rising edge.
REQ-005 i_ARst_L  in  1  reset; asynchronous, active-low.
REQ-006 i2_Speed  in  2  10=1000, 01=100, 00=10 Mb/s; 11 treated as 1000.
REQ-007 i_TxVal, i_TxEN, i_TxER, i8_TxD  in  1,1,1,8  MAC transmit byte and qualifiers.
REQ-008 o_TxRdy  out  1  MAC transmit byte accepted this cycle when high with i_TxVal.
REQ-009 o_TxEN, o_TxER, o8_TxD  out  1,1,8  replicated GMII stream to SGMII PCS.
REQ-010 i_RxEN, i_RxER, i8_RxD  in  1,1,8  replicated GMII stream from SGMII PCS.
REQ-011 o_RxVal, o_RxEN, o_RxER, o8_RxD  out  1,1,1,8  decimated byte, one-cycle strobe.
REQ-012 o_RxFrag  out  1  one-cycle pulse: partial receive symbol discarded.
REQ-013 o16_MisCnt  out  16  saturating count of receive symbols with copy mismatch.

Function
REQ-014 N SHALL be 1 at 1000, P_REP100 at 100, P_REP10 at 10 Mb/s.
REQ-015 i2_Speed SHALL be registered; any change SHALL return Tx FSM to IDLE, clear both counters, clear Rx reference and mismatch flag, and suppress o_RxVal/o_RxFrag for that cycle.
REQ-016 Tx FSM states IDLE and REPEAT; o_TxRdy SHALL be 1 in IDLE.
REQ-017 IDLE + i_TxVal: capture byte/EN/ER into hold register, tx counter=0, go to REPEAT.
REQ-018 Accepted byte SHALL appear on o_Tx* the cycle after acceptance; latency 1.
REQ-019 REPEAT: o_Tx* SHALL hold the captured value; counter increments each cycle.
REQ-020 REPEAT with counter==N-1: o_TxRdy=1; i_TxVal high loads the next byte with counter=0, remaining in REPEAT back-to-back with no gap.
REQ-021 REPEAT with counter==N-1 and no i_TxVal: go to IDLE; o_TxEN=o_TxER=0 and o8_TxD=0 from next cycle.
REQ-022 Each accepted byte SHALL appear on o_Tx* for exactly N consecutive cycles; at N=1 the FSM SHALL accept every cycle.
REQ-023 Rx active = i_RxEN|i_RxER; SOP = active and not active previous cycle.
REQ-024 Rx counter SHALL be 0 on SOP; while active, it SHALL increment and wrap N-1->0; while inactive, it SHALL be held at 0.
REQ-025 Active with counter==0: capture byte/EN/ER as reference and clear the mismatch flag.
REQ-026 Active with counter 1..N-1: any difference of {EN,ER,D} from the reference SHALL set the mismatch flag.
REQ-027 Active with counter==N-1: next cycle o_RxVal=1, o8_RxD/o_RxEN=reference, o_RxER=refER|mismatch (including the current cycle's compare); latency N from the first copy.
REQ-028 At N=1: o_RxVal=1 on every active cycle, registered pass-through with latency 1 and no mismatch check.
REQ-029 Active falls with counter!=0: symbol SHALL be discarded, no o_RxVal, o_RxFrag=1 for one cycle.
REQ-030 o16_MisCnt SHALL increment once per emitted symbol whose mismatch is set, saturating at 16'hFFFF.
REQ-031 SOP occurring in the cycle after a discard SHALL start a new symbol normally.
REQ-032 o_RxVal/o_RxFrag SHALL be 0 in all cycles other than those defined above; other Rx outputs SHALL hold their last value.

Reset
REQ-033 Reset low SHALL asynchronously force Tx FSM=IDLE, counters=0, and o_TxEN=o_TxER=0, o8_TxD=0.
REQ-034 Reset low SHALL asynchronously force o_RxVal=o_RxEN=o_RxER=o_RxFrag=0, o8_RxD=0, o16_MisCnt=0, and clear Rx reference/mismatch.
REQ-035 o_TxRdy SHALL read 1 while reset is low; reset asserted mid-symbol SHALL abandon that symbol without any output strobe.
REQ-036 Exit from reset SHALL be synchronous to i_GClk; the first edge after release SHALL operate normally.

Verification
REQ-037 Speed=01, send 0x55,0xD5 back-to-back -> o8_TxD=0x55 for 10 cycles then 0xD5 for 10, o_TxRdy high once per 10 cycles.
REQ-038 Speed=00, single byte 0xA5 -> o_TxEN=1 for exactly 100 cycles, then IDLE, o_TxEN=0.
REQ-039 Speed=01, Rx 3 symbols x10 copies 0x12,0x34,0x56 -> three o_RxVal pulses 10 cycles apart, ER=0, o16_MisCnt=0.
REQ-040 Speed=01, copy 7 of symbol corrupted to 0xFF -> that symbol o_RxER=1 with data = first copy; o16_MisCnt=1.
REQ-041 Speed=01, active drops after 4 copies -> no o_RxVal, o_RxFrag pulses once; next frame decodes correctly.
REQ-042 Speed changes 01->10 mid-symbol, plus reset asserted mid-REPEAT -> outputs zero, o_TxRdy=1, no spurious strobes; 1000 mode passes through at latency 1.

Source files
------------

// File: rtl/mrate_adapter_rep_if.sv
// ---------------------------------------------------------------------------
// mrate_adapter_rep_if
// Signal bundle between the MAC / SGMII PCS side and mrate_adapter_rep.
//   i2_Speed                          : line rate select (10=1000, 01=100, 00=10, 11=1000)
//   i_TxVal/i_TxEN/i_TxER/i8_TxD      : MAC transmit byte and qualifiers
//   o_TxRdy                           : transmit byte accepted when high with i_TxVal
//   o_TxEN/o_TxER/o8_TxD              : replicated GMII stream towards the PCS
//   i_RxEN/i_RxER/i8_RxD              : replicated GMII stream from the PCS
//   o_RxVal/o_RxEN/o_RxER/o8_RxD      : decimated receive byte with one-cycle strobe
//   o_RxFrag                          : one-cycle pulse when a partial symbol is dropped
//   o16_MisCnt                        : saturating count of symbols with copy mismatch
// Modport slave is the adapter itself; master is whoever drives it.
// ---------------------------------------------------------------------------
interface mrate_adapter_rep_if;
    logic [1:0]  i2_Speed;
    logic        i_TxVal;
    logic        i_TxEN;
    logic        i_TxER;
    logic [7:0]  i8_TxD;
    logic        o_TxRdy;
    logic        o_TxEN;
    logic        o_TxER;
    logic [7:0]  o8_TxD;
    logic        i_RxEN;
    logic        i_RxER;
    logic [7:0]  i8_RxD;
    logic        o_RxVal;
    logic        o_RxEN;
    logic        o_RxER;
    logic [7:0]  o8_RxD;
    logic        o_RxFrag;
    logic [15:0] o16_MisCnt;

    modport slave (
        input  i2_Speed, i_TxVal, i_TxEN, i_TxER, i8_TxD,
        input  i_RxEN, i_RxER, i8_RxD,
        output o_TxRdy, o_TxEN, o_TxER, o8_TxD,
        output o_RxVal, o_RxEN, o_RxER, o8_RxD, o_RxFrag, o16_MisCnt
    );

    modport master (
        output i2_Speed, i_TxVal, i_TxEN, i_TxER, i8_TxD,
        output i_RxEN, i_RxER, i8_RxD,
        input  o_TxRdy, o_TxEN, o_TxER, o8_TxD,
        input  o_RxVal, o_RxEN, o_RxER, o8_RxD, o_RxFrag, o16_MisCnt
    );
endinterface

// File: rtl/mrate_adapter_rep.sv
// ---------------------------------------------------------------------------
// mrate_adapter_rep
// GMII byte replicator / decimator letting a 1000 Mb/s SGMII PCS carry
// 100 and 10 Mb/s traffic. Each transmit byte is repeated N times towards
// the PCS; each N-copy receive symbol is collapsed back to one byte, with
// copy disagreements flagged through o_RxER and counted in o16_MisCnt.
// Ports:
//   i_GClk   : single clock, everything on its rising edge
//   i_ARst_L : asynchronous active-low reset
//   io_Bus   : mrate_adapter_rep_if.slave (speed, Tx and Rx streams)
// Parameters:
//   P_REP100 : copies per byte at 100 Mb/s
//   P_REP10  : copies per byte at 10 Mb/s
//   P_CW     : copy counter width, 2**P_CW must exceed P_REP10
// ---------------------------------------------------------------------------
module mrate_adapter_rep #(
    parameter int P_REP100 = 10,
    parameter int P_REP10  = 100,
    parameter int P_CW     = 7
) (
    input  logic                      i_GClk,
    input  logic                      i_ARst_L,
    mrate_adapter_rep_if.slave        io_Bus
);

    typedef enum logic {
        ST_IDLE,
        ST_REPEAT
    } tx_state_t;

    logic [1:0]      r2_Speed;
    logic            w_SpeedChg;
    logic [P_CW-1:0] w_NLast;

    tx_state_t       r_TxState;
    tx_state_t       w_TxStateNxt;
    logic [P_CW-1:0] r_TxCnt;
    logic [P_CW-1:0] w_TxCntNxt;
    logic            w_TxLoad;
    logic            w_TxLast;
    logic            w_TxRdy;
    logic            r_TxHoldEN;
    logic            r_TxHoldER;
    logic [7:0]      r8_TxHoldD;

    logic            w_RxAct;
    logic            w_RxFirst;
    logic            w_RxLast;
    logic            w_RxEmit;
    logic            w_Diff;
    logic            w_MisNow;
    logic            w_EmitEN;
    logic            w_EmitER;
    logic [7:0]      w8_EmitD;
    logic [P_CW-1:0] r_RxCnt;
    logic            r_RefEN;
    logic            r_RefER;
    logic [7:0]      r8_RefD;
    logic            r_Mis;
    logic            r_RxVal;
    logic            r_RxEN;
    logic            r_RxER;
    logic [7:0]      r8_RxD;
    logic            r_RxFrag;
    logic [15:0]     r16_MisCnt;

    // A raw change of the speed pins (including 10<->11) restarts both
    // directions so no symbol straddles two replication factors.
    assign w_SpeedChg = (io_Bus.i2_Speed != r2_Speed);

    // Last copy index (N-1) for the registered speed.
    always_comb begin
        case (r2_Speed)
            2'b01:   w_NLast = P_CW'(P_REP100 - 1);
            2'b00:   w_NLast = P_CW'(P_REP10 - 1);
            default: w_NLast = '0;
        endcase
    end

    // Speed register; resets to 1000 Mb/s so a different strap is seen as
    // a change on the first edge after reset release.
    always_ff @(posedge i_GClk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            r2_Speed <= 2'b10;
        end else begin
            r2_Speed <= io_Bus.i2_Speed;
        end
    end

    // ---------------- Transmit replicator ----------------

    assign w_TxLast = (r_TxCnt == w_NLast);

    // Next-state logic: a byte is taken in IDLE or on the last copy of the
    // current byte, which makes back-to-back bytes gap-free and N=1 accept
    // every cycle.
    always_comb begin
        w_TxStateNxt = r_TxState;
        w_TxCntNxt   = r_TxCnt;
        w_TxLoad     = 1'b0;
        w_TxRdy      = (r_TxState == ST_IDLE) || w_TxLast;
        if (w_SpeedChg) begin
            w_TxStateNxt = ST_IDLE;
            w_TxCntNxt   = '0;
        end else begin
            case (r_TxState)
                ST_IDLE: begin
                    if (io_Bus.i_TxVal) begin
                        w_TxLoad     = 1'b1;
                        w_TxCntNxt   = '0;
                        w_TxStateNxt = ST_REPEAT;
                    end
                end
                ST_REPEAT: begin
                    if (w_TxLast) begin
                        w_TxCntNxt = '0;
                        if (io_Bus.i_TxVal) begin
                            w_TxLoad = 1'b1;
                        end else begin
                            w_TxStateNxt = ST_IDLE;
                        end
                    end else begin
                        w_TxCntNxt = r_TxCnt + P_CW'(1);
                    end
                end
                default: begin
                    w_TxStateNxt = ST_IDLE;
                    w_TxCntNxt   = '0;
                end
            endcase
        end
    end

    // State, copy counter and hold register for the byte being repeated.
    always_ff @(posedge i_GClk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            r_TxState  <= ST_IDLE;
            r_TxCnt    <= '0;
            r_TxHoldEN <= 1'b0;
            r_TxHoldER <= 1'b0;
            r8_TxHoldD <= 8'h00;
        end else begin
            r_TxState <= w_TxStateNxt;
            r_TxCnt   <= w_TxCntNxt;
            if (w_TxLoad) begin
                r_TxHoldEN <= io_Bus.i_TxEN;
                r_TxHoldER <= io_Bus.i_TxER;
                r8_TxHoldD <= io_Bus.i8_TxD;
            end
        end
    end

    // The PCS only sees the hold register while repeating; IDLE is all zero.
    assign io_Bus.o_TxRdy = w_TxRdy;
    assign io_Bus.o_TxEN  = (r_TxState == ST_REPEAT) & r_TxHoldEN;
    assign io_Bus.o_TxER  = (r_TxState == ST_REPEAT) & r_TxHoldER;
    assign io_Bus.o8_TxD  = (r_TxState == ST_REPEAT) ? r8_TxHoldD : 8'h00;

    // ---------------- Receive decimator ----------------

    // The counter idles at 0, so the first active cycle of a frame is
    // always copy 0 without needing a separate start-of-packet register.
    assign w_RxAct   = io_Bus.i_RxEN | io_Bus.i_RxER;
    assign w_RxFirst = (r_RxCnt == '0);
    assign w_RxLast  = (r_RxCnt == w_NLast);
    assign w_RxEmit  = w_RxAct & w_RxLast & ~w_SpeedChg;
    assign w_Diff    = ({io_Bus.i_RxEN, io_Bus.i_RxER, io_Bus.i8_RxD} !=
                        {r_RefEN, r_RefER, r8_RefD});
    // Copy 0 is its own reference, so it can never mismatch (covers N=1).
    assign w_MisNow  = ~w_RxFirst & (r_Mis | w_Diff);
    assign w_EmitEN  = w_RxFirst ? io_Bus.i_RxEN : r_RefEN;
    assign w_EmitER  = (w_RxFirst ? io_Bus.i_RxER : r_RefER) | w_MisNow;
    assign w8_EmitD  = w_RxFirst ? io_Bus.i8_RxD : r8_RefD;

    // Copy counter, reference capture and sticky mismatch flag.
    always_ff @(posedge i_GClk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            r_RxCnt <= '0;
            r_RefEN <= 1'b0;
            r_RefER <= 1'b0;
            r8_RefD <= 8'h00;
            r_Mis   <= 1'b0;
        end else if (w_SpeedChg) begin
            r_RxCnt <= '0;
            r_RefEN <= 1'b0;
            r_RefER <= 1'b0;
            r8_RefD <= 8'h00;
            r_Mis   <= 1'b0;
        end else if (!w_RxAct) begin
            r_RxCnt <= '0;
        end else begin
            r_RxCnt <= w_RxLast ? '0 : (r_RxCnt + P_CW'(1));
            if (w_RxFirst) begin
                r_RefEN <= io_Bus.i_RxEN;
                r_RefER <= io_Bus.i_RxER;
                r8_RefD <= io_Bus.i8_RxD;
                r_Mis   <= 1'b0;
            end else if (w_Diff) begin
                r_Mis <= 1'b1;
            end
        end
    end

    // Output strobes and byte. Falling activity with a nonzero counter
    // means the symbol was cut short and is reported as a fragment.
    always_ff @(posedge i_GClk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            r_RxVal    <= 1'b0;
            r_RxFrag   <= 1'b0;
            r_RxEN     <= 1'b0;
            r_RxER     <= 1'b0;
            r8_RxD     <= 8'h00;
            r16_MisCnt <= 16'h0000;
        end else begin
            r_RxVal  <= w_RxEmit;
            r_RxFrag <= ~w_RxAct & ~w_RxFirst & ~w_SpeedChg;
            if (w_RxEmit) begin
                r_RxEN <= w_EmitEN;
                r_RxER <= w_EmitER;
                r8_RxD <= w8_EmitD;
                if (w_MisNow && (r16_MisCnt != 16'hFFFF)) begin
                    r16_MisCnt <= r16_MisCnt + 16'h0001;
                end
            end
        end
    end

    assign io_Bus.o_RxVal    = r_RxVal;
    assign io_Bus.o_RxFrag   = r_RxFrag;
    assign io_Bus.o_RxEN     = r_RxEN;
    assign io_Bus.o_RxER     = r_RxER;
    assign io_Bus.o8_RxD     = r8_RxD;
    assign io_Bus.o16_MisCnt = r16_MisCnt;

endmodule

// File: tb/tb_mrate_adapter_rep.sv
// ---------------------------------------------------------------------------
// tb_mrate_adapter_rep
// Testbench for mrate_adapter_rep: drives the adapter through its interface
// and compares every cycle against a behavioural model (owed-copies count
// for Tx, symbol list to expected strobe schedule for Rx).
// ---------------------------------------------------------------------------
module tb_mrate_adapter_rep;

    localparam int P_REP100 = 10;
    localparam int P_REP10  = 100;
    localparam int P_CW     = 7;
    localparam int RXMAX    = 2048;

    logic clock = 1'b0;
    logic rstN;

    mrate_adapter_rep_if bus();

    mrate_adapter_rep #(
        .P_REP100(P_REP100),
        .P_REP10 (P_REP10),
        .P_CW    (P_CW)
    ) dut (
        .i_GClk  (clock),
        .i_ARst_L(rstN),
        .io_Bus  (bus)
    );

    always #5 clock = ~clock;

    int vecCnt   = 0;
    int missCnt  = 0;
    int misModel = 0;
    logic [9:0] rxLastSym = 10'd0;

    logic [9:0] txSeq[$];

    logic [9:0] rxDrv   [RXMAX];
    bit         expVal  [RXMAX];
    bit         expFrag [RXMAX];
    bit         expMis  [RXMAX];
    logic [9:0] expSym  [RXMAX];
    int         rxLen;

    // Single comparison point: counts the vector and reports any miss.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        assert (obs === exp) else begin
            missCnt++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Symbols are packed {EN, ER, D[7:0]}.
    task automatic applyStimulus(input logic txVal, input logic [9:0] txSym, input logic [9:0] rxSym);
        bus.i_TxVal = txVal;
        bus.i_TxEN  = txSym[9];
        bus.i_TxER  = txSym[8];
        bus.i8_TxD  = txSym[7:0];
        bus.i_RxEN  = rxSym[9];
        bus.i_RxER  = rxSym[8];
        bus.i8_RxD  = rxSym[7:0];
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setSpeed(input logic [1:0] spd);
        bus.i2_Speed = spd;
        applyStimulus(1'b0, 10'd0, 10'd0);
        tick();
        tick();
    endtask

    function automatic int repFor(input logic [1:0] spd);
        if (spd == 2'b01) return P_REP100;
        if (spd == 2'b00) return P_REP10;
        return 1;
    endfunction

    task automatic checkStrobesQuiet(input string tag);
        checkOutput(tag, 32'({bus.o_RxVal, bus.o_RxFrag}), 32'd0);
    endtask

    // Tx model: each accepted byte is owed n output cycles; a new byte can
    // be taken once at most one owed cycle is left. Ends with a drain so
    // the design is idle on return.
    task automatic txRun(input int cycles, input int valPct, input int n);
        logic [9:0]  cur;
        logic [9:0]  offer;
        logic [10:0] expV;
        int          owed;
        bit          offerVal;
        bit          fromQ;
        owed = 0;
        cur  = 10'd0;
        for (int c = 0; c < cycles + n + 1; c++) begin
            expV = {(owed <= 1), (owed > 0) ? cur : 10'd0};
            checkOutput("tx_out", 32'({bus.o_TxRdy, bus.o_TxEN, bus.o_TxER, bus.o8_TxD}), 32'(expV));
            fromQ    = 1'b0;
            offerVal = 1'b0;
            offer    = 10'd0;
            if (c < cycles) begin
                if (txSeq.size() > 0) begin
                    offerVal = 1'b1;
                    fromQ    = 1'b1;
                    offer    = txSeq[0];
                end else if ($urandom_range(99) < valPct) begin
                    offerVal = 1'b1;
                    offer    = {1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom)};
                end
            end
            applyStimulus(offerVal, offer, 10'd0);
            @(posedge clock);
            if (offerVal && owed <= 1) begin
                cur  = offer;
                owed = n;
                if (fromQ) void'(txSeq.pop_front());
            end else if (owed > 0) begin
                owed--;
            end
            #1;
        end
        applyStimulus(1'b0, 10'd0, 10'd0);
    endtask

    task automatic rxClear();
        for (int i = 0; i < RXMAX; i++) begin
            rxDrv[i]   = 10'd0;
            expVal[i]  = 1'b0;
            expFrag[i] = 1'b0;
            expMis[i]  = 1'b0;
            expSym[i]  = 10'd0;
        end
        rxLen = 0;
    endtask

    // One symbol of 'copies' copies (copies < n means cut short); copy
    // index badCopy is replaced by badVal (-1 for none).
    task automatic rxSymbol(input logic [9:0] sym, input int n, input int copies,
                            input int badCopy, input logic [9:0] badVal);
        int  t0;
        bit  mis;
        t0 = rxLen;
        for (int k = 0; k < copies; k++) begin
            rxDrv[rxLen] = (k == badCopy) ? badVal : sym;
            rxLen++;
        end
        if (copies == n) begin
            mis = (n > 1) && (badCopy >= 1) && (badCopy < n) && (badVal != sym);
            expVal[t0 + n] = 1'b1;
            expMis[t0 + n] = mis;
            expSym[t0 + n] = {sym[9], sym[8] | mis, sym[7:0]};
        end else begin
            expFrag[t0 + copies + 1] = 1'b1;
        end
    endtask

    task automatic rxGap(input int g);
        rxLen += g;
    endtask

    task automatic rxRandom(input int n, input int frames);
        int         nSym;
        int         copies;
        int         bad;
        logic [9:0] sym;
        logic [9:0] badVal;
        for (int f = 0; f < frames; f++) begin
            if (rxLen + 3 * n + 8 > RXMAX) break;
            nSym = $urandom_range(3, 1);
            for (int s = 0; s < nSym; s++) begin
                sym    = {1'b1, 1'($urandom_range(7) == 0), 8'($urandom)};
                badVal = {1'b1, 1'($urandom_range(1)), 8'($urandom)};
                bad    = (n > 1 && $urandom_range(2) == 0) ? int'($urandom_range(n - 1, 1)) : -1;
                copies = n;
                if (s == nSym - 1 && n > 1 && $urandom_range(3) == 0)
                    copies = $urandom_range(n - 1, 1);
                rxSymbol(sym, n, copies, bad, badVal);
            end
            rxGap($urandom_range(3, 1));
        end
    endtask

    // Plays the built schedule; strobes, held byte and mismatch count are
    // checked every cycle.
    task automatic rxPlay();
        for (int i = 0; i <= rxLen; i++) begin
            if (expVal[i]) begin
                rxLastSym = expSym[i];
                if (expMis[i] && misModel < 65535) misModel++;
            end
            checkOutput("rx_strobe", 32'({bus.o_RxVal, bus.o_RxFrag}), 32'({expVal[i], expFrag[i]}));
            checkOutput("rx_sym", 32'({bus.o_RxEN, bus.o_RxER, bus.o8_RxD}), 32'(rxLastSym));
            checkOutput("rx_miscnt", 32'(bus.o16_MisCnt), 32'(misModel));
            applyStimulus(1'b0, 10'd0, rxDrv[i]);
            tick();
        end
        applyStimulus(1'b0, 10'd0, 10'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_tx"}, 32'({bus.o_TxRdy, bus.o_TxEN, bus.o_TxER, bus.o8_TxD}), 32'({1'b1, 10'd0}));
        checkOutput({tag, "_rx"}, 32'({bus.o_RxVal, bus.o_RxEN, bus.o_RxER, bus.o_RxFrag, bus.o8_RxD}), 32'd0);
        checkOutput({tag, "_mis"}, 32'(bus.o16_MisCnt), 32'd0);
    endtask

    initial begin
        rstN = 1'b1;
        bus.i2_Speed = 2'b10;
        applyStimulus(1'b0, 10'd0, 10'd0);
        #1 rstN = 1'b0;
        #2;
        checkResetState("reset");
        tick();
        tick();
        rstN = 1'b1;
        tick();

        // Tx at 100 Mb/s: directed 0x55,0xD5 back-to-back, then random.
        setSpeed(2'b01);
        txSeq.push_back({2'b10, 8'h55});
        txSeq.push_back({2'b10, 8'hD5});
        txRun(25, 0, P_REP100);
        txRun(200, 40, P_REP100);

        // Tx at 10 Mb/s: single byte 0xA5 held for 100 cycles, then random.
        setSpeed(2'b00);
        txSeq.push_back({2'b10, 8'hA5});
        txRun(5, 0, P_REP10);
        txRun(250, 30, P_REP10);

        // Tx at 1000 Mb/s and the 11 alias: one byte per cycle.
        setSpeed(2'b10);
        txRun(60, 70, repFor(2'b10));
        setSpeed(2'b11);
        txRun(40, 80, repFor(2'b11));

        // Rx at 100 Mb/s: clean symbols, one corrupted copy, a cut-short
        // symbol followed one cycle later by a fresh frame.
        setSpeed(2'b01);
        rxClear();
        rxSymbol({2'b10, 8'h12}, P_REP100, P_REP100, -1, 10'd0);
        rxSymbol({2'b10, 8'h34}, P_REP100, P_REP100, -1, 10'd0);
        rxSymbol({2'b10, 8'h56}, P_REP100, P_REP100, -1, 10'd0);
        rxGap(2);
        rxSymbol({2'b10, 8'hAB}, P_REP100, P_REP100, 6, {2'b10, 8'hFF});
        rxGap(2);
        rxSymbol({2'b10, 8'hC3}, P_REP100, 4, -1, 10'd0);
        rxGap(1);
        rxSymbol({2'b10, 8'h77}, P_REP100, P_REP100, -1, 10'd0);
        rxGap(2);
        rxPlay();
        rxClear();
        rxRandom(P_REP100, 20);
        rxPlay();

        // Rx at 10 Mb/s and 1000 Mb/s.
        setSpeed(2'b00);
        rxClear();
        rxRandom(P_REP10, 4);
        rxPlay();
        setSpeed(2'b10);
        rxClear();
        rxRandom(1, 40);
        rxPlay();

        // Speed change 01 -> 10 in the middle of a Tx byte and an Rx symbol.
        setSpeed(2'b01);
        applyStimulus(1'b1, {2'b10, 8'h3C}, {2'b10, 8'h99});
        tick();
        for (int k = 0; k < 3; k++) begin
            checkOutput("chg_tx_busy", 32'({bus.o_TxRdy, bus.o_TxEN, bus.o_TxER, bus.o8_TxD}), 32'({3'b010, 8'h3C}));
            checkStrobesQuiet("chg_rx_busy");
            applyStimulus(1'b0, 10'd0, {2'b10, 8'h99});
            tick();
        end
        bus.i2_Speed = 2'b10;
        applyStimulus(1'b0, 10'd0, 10'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("chg_tx_idle", 32'({bus.o_TxRdy, bus.o_TxEN, bus.o_TxER, bus.o8_TxD}), 32'({1'b1, 10'd0}));
            checkStrobesQuiet("chg_rx_quiet");
            checkOutput("chg_miscnt", 32'(bus.o16_MisCnt), 32'(misModel));
        end
        txRun(30, 60, 1);
        rxClear();
        rxRandom(1, 10);
        rxPlay();

        // Reset asserted mid-REPEAT with an Rx symbol in flight.
        setSpeed(2'b01);
        applyStimulus(1'b1, {2'b10, 8'h5A}, {2'b10, 8'h42});
        tick();
        applyStimulus(1'b0, 10'd0, {2'b10, 8'h42});
        tick();
        applyStimulus(1'b0, 10'd0, 10'd0);
        #3 rstN = 1'b0;
        #1;
        misModel  = 0;
        rxLastSym = 10'd0;
        checkResetState("midrst");
        @(posedge clock);
        #1;
        checkResetState("midrst_hold");
        rstN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("post_rst_tx", 32'({bus.o_TxRdy, bus.o_TxEN, bus.o_TxER, bus.o8_TxD}), 32'({1'b1, 10'd0}));
            checkStrobesQuiet("post_rst_rx");
        end
        txRun(30, 50, P_REP100);
        rxClear();
        rxRandom(P_REP100, 4);
        rxPlay();

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
